// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: synchronizes the SPI pins into the i_clk domain and
// shifts DATA_WIDTH-bit words in all four SPI modes, with a tx holding register.
module spi_slave_shift #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsb_first,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_pos_edge,
  output logic                  o_neg_edge,
  output logic                  o_busy,
  output logic                  o_tx_underrun
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r, warm_r;
  logic                   sclk_d_r, cs_d_r;
  logic                   sclk_s, cs_s, mosi_s, warm_s;
  logic                   rise_s, fall_s, cs_fall_s;
  logic                   pos_r, neg_r;
  state_t                 state_r, state_next_s;
  logic                   start_s, run_s;
  logic                   cpol_r, cpha_r, lsb_r;
  logic                   lead_s, trail_s, sample_ev_s, shift_ev_s;
  logic                   word_done_s, reload_s, advance_s, tx_load_s, tx_ready_s;
  logic [DATA_WIDTH-1:0]  tx_shift_r, rx_shift_r, rx_next_s, hold_r, rx_data_r;
  logic                   hold_full_r, pending_r, first_r, rx_valid_r, underrun_r;
  logic [CNT_W-1:0]       bit_cnt_r;

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign warm_s    = warm_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_d_r;
  assign fall_s    = ~sclk_s & sclk_d_r;
  // cs_d_r only records a high that really came from the pin, so a cs_n held
  // low across reset release never looks like a falling edge.
  assign cs_fall_s = cs_d_r & ~cs_s;

  // Pin synchronizers, edge-detect history and edge pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      warm_r      <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b0;
      pos_r       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_mosi};
      warm_r      <= {warm_r[SYNC_STAGES-2:0], 1'b1};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s & warm_s;
      pos_r       <= i_enable & rise_s;
      neg_r       <= i_enable & fall_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and frame start / run strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    run_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable && cs_fall_s) begin
          state_next_s = ST_ACTIVE;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!i_enable || cs_s) begin
          state_next_s = ST_IDLE;
        end else begin
          run_s = 1'b1;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Mode-dependent edge roles and datapath strobes
  always_comb begin
    lead_s      = cpol_r ? neg_r : pos_r;
    trail_s     = cpol_r ? pos_r : neg_r;
    sample_ev_s = run_s & (cpha_r ? trail_s : lead_s);
    shift_ev_s  = run_s & (cpha_r ? lead_s : trail_s);
    word_done_s = sample_ev_s & (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
    // cpha=0 reloads on the shift edge after a word, cpha=1 at the word end itself
    reload_s    = start_s | (cpha_r & word_done_s) | (~cpha_r & shift_ev_s & pending_r);
    advance_s   = shift_ev_s & ~(cpha_r ? first_r : pending_r);
    rx_next_s   = lsb_r ? {mosi_s, rx_shift_r[DATA_WIDTH-1:1]}
                        : {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
    tx_ready_s  = warm_r[0] & i_enable & ~hold_full_r;
    tx_load_s   = i_tx_valid & tx_ready_s;
  end

  // Mode latch, bit counter and word-boundary flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      lsb_r     <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
      pending_r <= 1'b0;
      first_r   <= 1'b0;
    end else if (start_s) begin
      cpol_r    <= i_cpol;
      cpha_r    <= i_cpha;
      lsb_r     <= i_lsb_first;
      bit_cnt_r <= {CNT_W{1'b0}};
      pending_r <= 1'b0;
      first_r   <= 1'b1;
    end else if (run_s) begin
      if (sample_ev_s) begin
        bit_cnt_r <= word_done_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);
      end
      if (word_done_s) begin
        pending_r <= ~cpha_r;
        first_r   <= cpha_r;
      end else if (shift_ev_s) begin
        pending_r <= 1'b0;
        first_r   <= 1'b0;
      end
    end else begin
      bit_cnt_r <= {CNT_W{1'b0}};
      pending_r <= 1'b0;
    end
  end

  // Receive shift register and received-word strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_shift_r <= {DATA_WIDTH{1'b0}};
      rx_data_r  <= {DATA_WIDTH{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= word_done_s;
      if (start_s) begin
        rx_shift_r <= {DATA_WIDTH{1'b0}};
      end else if (sample_ev_s) begin
        rx_shift_r <= rx_next_s;
      end
      if (word_done_s) begin
        rx_data_r <= rx_next_s;
      end
    end
  end

  // Transmit shift register, underrun pulse and holding register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_shift_r  <= {DATA_WIDTH{1'b0}};
      underrun_r  <= 1'b0;
      hold_r      <= {DATA_WIDTH{1'b0}};
      hold_full_r <= 1'b0;
    end else begin
      underrun_r <= reload_s & ~hold_full_r;
      if (reload_s) begin
        tx_shift_r <= hold_full_r ? hold_r : {DATA_WIDTH{1'b0}};
      end else if (advance_s) begin
        tx_shift_r <= lsb_r ? {1'b0, tx_shift_r[DATA_WIDTH-1:1]}
                            : {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
      end
      // a same-cycle reload already took the old contents, so new data lands
      if (!i_enable) begin
        hold_r      <= {DATA_WIDTH{1'b0}};
        hold_full_r <= 1'b0;
      end else if (tx_load_s) begin
        hold_r      <= i_tx_data;
        hold_full_r <= 1'b1;
      end else if (reload_s) begin
        hold_r      <= {DATA_WIDTH{1'b0}};
        hold_full_r <= 1'b0;
      end
    end
  end

  assign o_miso        = lsb_r ? tx_shift_r[0] : tx_shift_r[DATA_WIDTH-1];
  assign o_miso_oe     = (state_r == ST_ACTIVE);
  assign o_busy        = (state_r == ST_ACTIVE);
  assign o_tx_ready    = tx_ready_s;
  assign o_rx_data     = rx_data_r;
  assign o_rx_valid    = rx_valid_r;
  assign o_pos_edge    = pos_r;
  assign o_neg_edge    = neg_r;
  assign o_tx_underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave_shift.sv
// Randomized bench for spi_slave_shift: a pin-level SPI master, a word-level
// reference model and a scoreboard monitor that performs every comparison.
module tb_spi_slave_shift;

  localparam int W = 8;
  localparam int S = 2;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
  logic [W-1:0] tx_data = 8'h00;
  logic miso, miso_oe, tx_ready, rx_valid, pos_edge, neg_edge, busy, tx_underrun;
  logic [W-1:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_shift #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
    .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_pos_edge(pos_edge), .o_neg_edge(neg_edge),
    .o_busy(busy), .o_tx_underrun(tx_underrun)
  );

  int checks = 0, errors = 0;
  int rx_pulses = 0, pos_cnt = 0, neg_cnt = 0, und_cnt = 0;
  logic [W-1:0] rx_q[$];
  string        nm_q[$];
  logic [31:0]  got_q[$], exp_q[$];

  // Scoreboard monitor: the only process that compares and counts
  always @(negedge clk) begin
    if (pos_edge) pos_cnt++;
    if (neg_edge) neg_cnt++;
    if (tx_underrun) und_cnt++;
    if (rx_valid) begin
      rx_pulses++;
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got=%0h exp=none", rx_data);
      end else begin
        logic [W-1:0] e;
        e = rx_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data got=%0h exp=%0h", rx_data, e);
        end
      end
    end
    while (nm_q.size() > 0) begin
      string n;
      logic [31:0] g, e;
      n = nm_q.pop_front();
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got=%0h exp=%0h", n, g, e);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    nm_q.push_back(n);
    got_q.push_back(g);
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_hold(input logic [W-1:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_valid = 1'b1;
        tx_data  = v;
        @(negedge clk);
        tx_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) chk("hold_ready_timeout", 32'd0, 32'd1);
  endtask

  // Frame description consumed by run_frame
  bit           f_cpol, f_cpha, f_lsb, f_pre, f_pre_in_hold;
  int           f_nw;
  logic [W-1:0] f_pre_val;
  logic [W-1:0] f_mo[4];
  bit           f_ref[5];
  logic [W-1:0] f_ref_val[5];

  task automatic run_frame();
    logic [W-1:0] load_v[5];
    logic [W-1:0] mw;
    logic         b;
    bit           bits[$];
    int           exp_und, und0, j;
    // every word boundary loads the tx register: frame start plus one per word
    load_v[0] = f_pre ? f_pre_val : 8'h00;
    exp_und   = f_pre ? 0 : 1;
    for (int k = 1; k <= f_nw; k++) begin
      load_v[k] = f_ref[k] ? f_ref_val[k] : 8'h00;
      if (!f_ref[k]) exp_und++;
    end
    for (int w = 0; w < f_nw; w++)
      for (int i = 0; i < W; i++)
        bits.push_back(f_lsb ? f_mo[w][i] : f_mo[w][W-1-i]);
    @(negedge clk);
    cpol = f_cpol; cpha = f_cpha; lsb = f_lsb; sclk = f_cpol; mosi = 1'b0;
    if (f_pre && !f_pre_in_hold) write_hold(f_pre_val);
    wait_cyc(H);
    und0 = und_cnt;
    for (int w = 0; w < f_nw; w++) rx_q.push_back(f_mo[w]);
    if (!f_cpha) mosi = bits[0];
    cs_n = 1'b0;
    wait_cyc(H);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    chk("oe_in_frame", {31'd0, miso_oe}, 32'd1);
    cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
    for (int w = 0; w < f_nw; w++) begin
      if (f_ref[w+1]) write_hold(f_ref_val[w+1]);
      mw = 8'h00;
      for (int i = 0; i < W; i++) begin
        j = w * W + i;
        b = 1'b0;
        if (f_cpha) mosi = bits[j];
        else b = miso;
        sclk = ~sclk;
        wait_cyc(H);
        if (f_cpha) b = miso;
        sclk = ~sclk;
        if (!f_cpha && j + 1 < bits.size()) mosi = bits[j+1];
        wait_cyc(H);
        if (f_lsb) mw[i] = b;
        else mw = {mw[W-2:0], b};
      end
      chk("miso_word", {24'd0, mw}, {24'd0, load_v[w]});
    end
    cs_n = 1'b1;
    wait_cyc(2 * H);
    chk("underruns", und_cnt - und0, exp_und);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("rx_q_drained", rx_q.size(), 32'd0);
  endtask

  task automatic set_frame(input bit pl, input bit ph, input bit lf, input int nw,
                           input bit pre, input logic [W-1:0] pv);
    f_cpol = pl; f_cpha = ph; f_lsb = lf; f_nw = nw;
    f_pre = pre; f_pre_val = pv; f_pre_in_hold = 1'b0;
    for (int k = 0; k < 5; k++) begin f_ref[k] = 1'b0; f_ref_val[k] = 8'h00; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_oe"}, {31'd0, miso_oe}, 32'd0);
    chk({tag, "_miso"}, {31'd0, miso}, 32'd0);
    chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_pos"}, {31'd0, pos_edge}, 32'd0);
    chk({tag, "_neg"}, {31'd0, neg_edge}, 32'd0);
    chk({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, p0, n0;
    bit seen;
    enable = 1'b1;
    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(5);
    chk("ready_idle", {31'd0, tx_ready}, 32'd1);

    // edge pulse latency and width
    @(negedge clk); sclk = 1'b1; n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); n++; @(negedge clk);
      if (pos_edge) seen = 1'b1;
    end
    chk("pos_latency", seen ? n : 0, S + 1);
    @(negedge clk); chk("pos_width", {31'd0, pos_edge}, 32'd0);
    wait_cyc(H);
    sclk = 1'b0; n = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); n++; @(negedge clk);
      if (neg_edge) seen = 1'b1;
    end
    chk("neg_latency", seen ? n : 0, S + 1);
    wait_cyc(H);

    // disable suppresses pulses and empties the holding register
    write_hold(8'h77);
    chk("ready_full", {31'd0, tx_ready}, 32'd0);
    enable = 1'b0;
    wait_cyc(2);
    p0 = pos_cnt; n0 = neg_cnt;
    chk("ready_disabled", {31'd0, tx_ready}, 32'd0);
    sclk = 1'b1; wait_cyc(H); sclk = 1'b0; wait_cyc(H);
    chk("no_pos_disabled", pos_cnt - p0, 32'd0);
    chk("no_neg_disabled", neg_cnt - n0, 32'd0);
    enable = 1'b1;
    wait_cyc(2);
    chk("hold_cleared", {31'd0, tx_ready}, 32'd1);

    // directed frames
    set_frame(1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5); f_mo[0] = 8'h3C; run_frame();
    set_frame(1'b1, 1'b1, 1'b1, 1, 1'b1, 8'h0F); f_mo[0] = 8'h81; run_frame();
    set_frame(1'b0, 1'b1, 1'b0, 2, 1'b1, 8'h11); f_mo[0] = 8'h5A; f_mo[1] = 8'hC3;
    f_ref[1] = 1'b1; f_ref_val[1] = 8'h22; run_frame();
    set_frame(1'b0, 1'b1, 1'b0, 2, 1'b1, 8'h33); f_mo[0] = 8'h96; f_mo[1] = 8'h69;
    run_frame();

    // cs_n raised after 5 bits: no word, holding register survives
    @(negedge clk); cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sclk = 1'b0;
    wait_cyc(H);
    cs_n = 1'b0; wait_cyc(H);
    write_hold(8'h5A);
    p0 = rx_pulses;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom); sclk = 1'b1; wait_cyc(H); sclk = 1'b0; wait_cyc(H);
    end
    cs_n = 1'b1; wait_cyc(2 * H);
    chk("abort_no_rx", rx_pulses - p0, 32'd0);
    chk("abort_hold_kept", {31'd0, tx_ready}, 32'd0);
    set_frame(1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h5A); f_pre_in_hold = 1'b1;
    f_mo[0] = 8'hE7; run_frame();

    // random frames
    for (int t = 0; t < 14; t++) begin
      set_frame(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3),
                1'($urandom), 8'($urandom));
      for (int w = 0; w < 4; w++) f_mo[w] = 8'($urandom);
      for (int k = 1; k < 5; k++) begin
        f_ref[k] = 1'($urandom); f_ref_val[k] = 8'($urandom);
      end
      run_frame();
    end

    // reset mid-word forces reset outputs at once; held-low cs_n must not restart
    @(negedge clk); cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sclk = 1'b0;
    write_hold(8'hFF);
    wait_cyc(H);
    cs_n = 1'b0; wait_cyc(H);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; sclk = 1'b1; wait_cyc(H); sclk = 1'b0; wait_cyc(H);
    end
    sclk = 1'b1; wait_cyc(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk); sclk = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(30);
    chk("no_restart_low_cs", {31'd0, busy}, 32'd0);
    cs_n = 1'b1; wait_cyc(H);
    set_frame(1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h00); f_mo[0] = 8'h4D; f_mo[1] = 8'hB2;
    f_ref[1] = 1'b1; f_ref_val[1] = 8'hC6; run_frame();

    wait_cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
